// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period calculation, serialiser state encoding and frame constants.
package uart_pkg;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_BITS = 8;

   // One-hot encoding, same style as the receiver so both FSMs read alike in waveforms.
   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      START = 4'b0010,
      DATA  = 4'b0100,
      STOP  = 4'b1000
   } txState_e;

   // Clock cycles per serial bit, rounded to the nearest integer.
   function automatic int calcCpb(input int clkFreq, input int baudRate);
      return (clkFreq + baudRate / 2) / baudRate;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte producer handshake into the UART transmitter.
interface uart_tx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock show-ahead FIFO; the head entry is visible on rd_data_o whenever not empty.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en_i,
   input  logic [WIDTH-1:0]       wr_data_i,
   input  logic                   rd_en_i,
   output logic [WIDTH-1:0]       rd_data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic             doPush;
   logic             doPop;

   assign full_o    = (count_q == FULL_COUNT);
   assign empty_o   = (count_q == '0);
   assign doPush    = wr_en_i && !full_o;
   assign doPop     = rd_en_i && !empty_o;
   assign rd_data_o = mem_q[rdPtr_q];
   assign count_o   = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= wr_data_i;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes from the producer and sends 8N1 frames on tx_o, LSB first.
module uart_tx import uart_pkg::*; #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   uart_tx_if.slave                    bus,
   output logic                        tx_o,
   output logic                        tx_busy_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

   localparam int             CPB        = calcCpb(CLK_FREQ, BAUD_RATE);
   localparam logic [15:0]    LAST_CYCLE = 16'(CPB - 1);
   localparam logic [2:0]     LAST_BIT   = 3'(DATA_BITS - 1);

   txState_e                 state_q, state_d;
   logic [15:0]              cycleCount_q, cycleCount_d;
   logic [2:0]               bitIndex_q, bitIndex_d;
   logic [DATA_BITS-1:0]     shift_q, shift_d;
   logic                     tx_q, tx_d;
   logic                     busy_q;
   logic                     fifoFull;
   logic                     fifoEmpty;
   logic                     fifoPop;
   logic [DATA_BITS-1:0]     fifoData;
   logic                     bitDone;

   assign bus.tx_ready = !fifoFull;
   assign bitDone      = (cycleCount_q == LAST_CYCLE);
   assign tx_o         = tx_q;
   assign tx_busy_o    = busy_q;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (bus.tx_valid && !rst),
      .wr_data_i (bus.tx_data),
      .rd_en_i   (fifoPop),
      .rd_data_o (fifoData),
      .count_o   (fifo_count_o),
      .full_o    (fifoFull),
      .empty_o   (fifoEmpty)
   );

   // STOP pops the next byte directly into START so queued frames leave with no idle gap.
   always_comb begin
      state_d      = state_q;
      cycleCount_d = cycleCount_q + 16'd1;
      bitIndex_d   = bitIndex_q;
      shift_d      = shift_q;
      tx_d         = tx_q;
      fifoPop      = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d         = STOP_BIT;
            cycleCount_d = '0;
            if (!fifoEmpty) begin
               fifoPop = 1'b1;
               shift_d = fifoData;
               tx_d    = START_BIT;
               state_d = START;
            end
         end
         START: begin
            if (bitDone) begin
               cycleCount_d = '0;
               bitIndex_d   = '0;
               tx_d         = shift_q[0];
               state_d      = DATA;
            end
         end
         DATA: begin
            if (bitDone) begin
               cycleCount_d = '0;
               if (bitIndex_q == LAST_BIT) begin
                  tx_d    = STOP_BIT;
                  state_d = STOP;
               end else begin
                  shift_d    = shift_q >> 1;
                  tx_d       = shift_q[1];
                  bitIndex_d = bitIndex_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (bitDone) begin
               cycleCount_d = '0;
               if (!fifoEmpty) begin
                  fifoPop = 1'b1;
                  shift_d = fifoData;
                  tx_d    = START_BIT;
                  state_d = START;
               end else begin
                  tx_d    = STOP_BIT;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            cycleCount_d = '0;
            bitIndex_d   = '0;
            tx_d         = STOP_BIT;
            state_d      = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cycleCount_q <= '0;
         bitIndex_q   <= '0;
         shift_q      <= '0;
         tx_q         <= STOP_BIT;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cycleCount_q <= cycleCount_d;
         bitIndex_q   <= bitIndex_d;
         shift_q      <= shift_d;
         tx_q         <= tx_d;
         busy_q       <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: decodes frames from the serial line and checks them against hand-derived values.
module tb_uart_tx;

   localparam int CPB_A = 9;
   localparam int CPB_B = 868;
   localparam int CPB_C = 5208;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_if ifA ();
   uart_tx_if ifB ();
   uart_tx_if ifC ();

   logic       txA, txB, txC;
   logic       busyA, busyB, busyC;
   logic [4:0] countA, countB, countC;

   uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(115200), .FIFO_DEPTH(16)) dutA (
      .clk(clk), .rst(rst), .bus(ifA), .tx_o(txA), .tx_busy_o(busyA), .fifo_count_o(countA));
   uart_tx #(.CLK_FREQ(100000000), .BAUD_RATE(115200), .FIFO_DEPTH(16)) dutB (
      .clk(clk), .rst(rst), .bus(ifB), .tx_o(txB), .tx_busy_o(busyB), .fifo_count_o(countB));
   uart_tx #(.CLK_FREQ(50000000), .BAUD_RATE(9600), .FIFO_DEPTH(16)) dutC (
      .clk(clk), .rst(rst), .bus(ifC), .tx_o(txC), .tx_busy_o(busyC), .fifo_count_o(countC));

   int   sel = 0;
   logic txSel, busySel, readySel;

   always_comb begin
      txSel    = txA;
      busySel  = busyA;
      readySel = ifA.tx_ready;
      case (sel)
         1: begin txSel = txB; busySel = busyB; readySel = ifB.tx_ready; end
         2: begin txSel = txC; busySel = busyC; readySel = ifC.tx_ready; end
         default: ;
      endcase
   end

   int checks = 0;
   int failures = 0;
   int cycleCnt = 0;
   int busyTotal = 0;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;
   always @(negedge clk) if (busySel === 1'b1) busyTotal <= busyTotal + 1;

   int         nAcc, prevSt, zeros, acc, acc2, st, st2, tmp;
   logic [9:0] frame;
   logic       stable;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyReset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic driveValid(input logic v, input logic [7:0] b);
      case (sel)
         1: begin ifB.tx_valid = v; ifB.tx_data = b; end
         2: begin ifC.tx_valid = v; ifC.tx_data = b; end
         default: begin ifA.tx_valid = v; ifA.tx_data = b; end
      endcase
   endtask

   // Offers one byte; returns at the falling edge right after the accepting edge.
   task automatic applyStimulus(input logic [7:0] b, output int accCyc);
      int guard = 0;
      driveValid(1'b1, b);
      while (readySel !== 1'b1 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("pushReady", readySel, 1);
      @(negedge clk);
      accCyc = cycleCnt;
      driveValid(1'b0, b);
   endtask

   // Waits for a start bit, then samples every bit mid-period; frame[0] is the start bit.
   task automatic rxFrame(input int cpb, output logic [9:0] bits, output int startCyc, output logic isStable);
      int   guard = 0;
      logic first = 1'b0;
      bits = '0;
      while (txSel !== 1'b0 && guard < 40 * cpb) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("rxStartSeen", txSel, 0);
      startCyc = cycleCnt;
      isStable = 1'b1;
      for (int j = 0; j < 10 * cpb; j++) begin
         if (j % cpb == 0) first = txSel;
         else if (txSel !== first) isStable = 1'b0;
         if (j % cpb == cpb / 2) bits[j / cpb] = txSel;
         @(negedge clk);
      end
   endtask

   task automatic runSingle(input string name, input int cpb, input logic [7:0] b, input logic [9:0] expFrame);
      int         a, s, b0;
      logic [9:0] f;
      logic       stb;
      b0 = busyTotal;
      checkOutput({name, "Idle"}, txSel, 1);
      applyStimulus(b, a);
      checkOutput({name, "TxBeforeStart"}, txSel, 1);
      rxFrame(cpb, f, s, stb);
      checkOutput({name, "StartLatency"}, s - a, 1);
      checkOutput({name, "Frame"}, f, expFrame);
      checkOutput({name, "BitStable"}, stb, 1);
      repeat (2) @(negedge clk);
      checkOutput({name, "BusyCycles"}, busyTotal - b0, 10 * cpb);
   endtask

   initial begin
      #1_500_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ifA.tx_valid = 1'b0; ifA.tx_data = '0;
      ifB.tx_valid = 1'b0; ifB.tx_data = '0;
      ifC.tx_valid = 1'b0; ifC.tx_data = '0;
      @(negedge clk);
      applyReset();

      checkOutput("rstTx", txA, 1);
      checkOutput("rstBusy", busyA, 0);
      checkOutput("rstCount", countA, 0);
      checkOutput("rstReady", ifA.tx_ready, 1);
      checkOutput("rstTxB", txB, 1);
      checkOutput("rstCountB", countB, 0);
      checkOutput("rstCountC", countC, 0);

      // 0xA5 LSB first framed: 0,1,0,1,0,0,1,0,1,1 -> 10'h34A
      runSingle("a5", CPB_A, 8'hA5, 10'h34A);

      // Producer holds valid from reset; the serialiser drains 17 frames back to back.
      applyReset();
      fork
         begin
            ifA.tx_data = 8'h00;
            ifA.tx_valid = 1'b1;
            nAcc = 0;
            for (int k = 0; k < 100; k++) begin
               if (ifA.tx_ready !== 1'b1) break;
               @(negedge clk);
               nAcc++;
               ifA.tx_data = ifA.tx_data + 8'd1;
            end
            checkOutput("fillAccepted", nAcc, 17);
            checkOutput("fillCount", countA, 16);
            ifA.tx_data = 8'h77;
            repeat (40) @(negedge clk);
            checkOutput("fullIgnoreCount", countA, 16);
            checkOutput("fullReady", ifA.tx_ready, 0);
            ifA.tx_valid = 1'b0;
         end
         begin
            for (int f = 0; f < 17; f++) begin
               rxFrame(CPB_A, frame, st, stable);
               checkOutput($sformatf("streamFrame%0d", f), frame, {1'b1, 8'(f), 1'b0});
               checkOutput($sformatf("streamStable%0d", f), stable, 1);
               if (f > 0) checkOutput($sformatf("streamSpacing%0d", f), st - prevSt, 10 * CPB_A);
               prevSt = st;
            end
         end
      join
      zeros = 0;
      repeat (3 * CPB_A) begin
         if (txSel !== 1'b1) zeros++;
         @(negedge clk);
      end
      checkOutput("streamIdleAfter", zeros, 0);
      checkOutput("streamBusyLow", busyA, 0);
      checkOutput("streamCountEmpty", countA, 0);

      // 0x00 then 0xFF back to back.
      applyReset();
      applyStimulus(8'h00, acc);
      applyStimulus(8'hFF, acc2);
      rxFrame(CPB_A, frame, st, stable);
      checkOutput("b2bFrame00", frame, 10'h200);
      checkOutput("b2bStable00", stable, 1);
      checkOutput("b2bFirstStart", st - acc, 1);
      rxFrame(CPB_A, frame, st2, stable);
      checkOutput("b2bFrameFF", frame, 10'h3FE);
      checkOutput("b2bStableFF", stable, 1);
      checkOutput("b2bSecondStart", st2 - st, 10 * CPB_A);

      // Reset in the middle of data bit 3 of 0x3C with five bytes queued behind it.
      applyReset();
      applyStimulus(8'h3C, acc);
      for (int k = 1; k <= 5; k++) applyStimulus(8'(k), tmp);
      while (cycleCnt < acc + 1 + 4 * CPB_A + CPB_A / 2) @(negedge clk);
      checkOutput("midBit3Tx", txA, 1);
      checkOutput("midBit3Busy", busyA, 1);
      checkOutput("midQueued", countA, 5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midRstTx", txA, 1);
      checkOutput("midRstBusy", busyA, 0);
      checkOutput("midRstCount", countA, 0);
      checkOutput("midRstReady", ifA.tx_ready, 1);
      zeros = 0;
      repeat (12 * CPB_A) begin
         if (txA !== 1'b1 || busyA !== 1'b0) zeros++;
         @(negedge clk);
      end
      checkOutput("midRstQuiet", zeros, 0);

      // Default 100 MHz / 115200 instance.
      sel = 1;
      @(negedge clk);
      runSingle("dflt", CPB_B, 8'hA5, 10'h34A);

      // 50 MHz / 9600 instance; 0x5A framed -> 10'h2B4.
      sel = 2;
      @(negedge clk);
      runSingle("slow", CPB_C, 8'h5A, 10'h2B4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
